// File: rtl/tdm_frame_demux.sv
// Receive side of the TDM link: gathers N serial W-bit slots behind an SOF
// marker and publishes each complete frame as parallel registered channels.

module tdm_slot_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic [W-1:0] din,
  input  logic         commit,
  output logic [W-1:0] sh,
  output logic [W-1:0] ch
);
  logic [W-1:0] sh_d, sh_q, ch_d, ch_q;

  // Commit takes the post-write shadow so the final slot lands on the same edge.
  always_comb begin
    sh_d = wr ? din : sh_q;
    ch_d = commit ? sh_d : ch_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
      ch_q <= '0;
    end else begin
      sh_q <= sh_d;
      ch_q <= ch_d;
    end
  end

  assign sh = sh_q;
  assign ch = ch_q;
endmodule

module tdm_frame_demux #(
  parameter int W       = 8,
  parameter int N       = 4,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  input  logic           in_sof,
  output logic [N*W-1:0] ch_data,
  output logic           out_valid,
  output logic           err,
  output logic [7:0]     frame_cnt
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [7:0]    TO   = 8'(TIMEOUT);

  localparam logic [0:0] HUNT    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  logic [0:0]            state_d, state_q;
  logic [CW-1:0]         cnt_d, cnt_q;
  logic [7:0]            idle_d, idle_q;
  logic [7:0]            frame_cnt_d, frame_cnt_q;
  logic                  out_valid_d, out_valid_q;
  logic                  err_d, err_q;
  logic                  slot_wr, commit;
  logic [CW-1:0]         wr_idx;
  logic [7:0]            idle_inc;
  logic [N-1:0]          lane_wr;
  logic [N-1:0][W-1:0]   sh, ch;

  assign idle_inc = idle_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idle_d      = idle_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = 1'b0;
    slot_wr     = 1'b0;
    commit      = 1'b0;
    wr_idx      = cnt_q;
    case (state_q)
      HUNT: begin
        if (in_valid && in_sof) begin
          slot_wr = 1'b1;
          wr_idx  = '0;
          cnt_d   = CW'(1);
          idle_d  = '0;
          state_d = COLLECT;
        end
      end
      default: begin
        if (in_valid) begin
          idle_d  = '0;
          slot_wr = 1'b1;
          if (in_sof) begin
            // Short frame: drop the partial and restart on this beat.
            wr_idx = '0;
            cnt_d  = CW'(1);
            err_d  = 1'b1;
          end else if (cnt_q == LAST) begin
            commit      = 1'b1;
            cnt_d       = '0;
            frame_cnt_d = frame_cnt_q + 8'd1;
            state_d     = HUNT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (idle_inc == TO) begin
          err_d   = 1'b1;
          idle_d  = '0;
          cnt_d   = '0;
          state_d = HUNT;
        end else begin
          idle_d = idle_inc;
        end
      end
    endcase
    out_valid_d = commit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      cnt_q       <= '0;
      idle_q      <= '0;
      frame_cnt_q <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
      frame_cnt_q <= frame_cnt_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    assign lane_wr[k] = slot_wr && (wr_idx == CW'(k));
    tdm_slot_lane #(.W(W)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr     (lane_wr[k]),
      .din    (in_data),
      .commit (commit),
      .sh     (sh[k]),
      .ch     (ch[k])
    );
  end

  assign ch_data   = ch;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_tdm_frame_demux.sv
// Scoreboard bench for tdm_frame_demux: the driver queues expected frames and
// error pulses with their due cycle; a negedge monitor pops and compares.

module tb_tdm_frame_demux;
  localparam int W = 8;
  localparam int N = 4;
  localparam int TIMEOUT = 15;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_sof = 1'b0;
  logic [N*W-1:0] ch_data;
  logic           out_valid;
  logic           err;
  logic [7:0]     frame_cnt;

  typedef struct {
    int             cyc;
    logic [N*W-1:0] data;
    logic [7:0]     fc;
  } exp_t;

  exp_t exp_q[$];
  int   err_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] fc_model = 8'd0;
  logic [N*W-1:0] last_frame = '0;

  tdm_frame_demux #(.W(W), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .ch_data   (ch_data),
    .out_valid (out_valid),
    .err       (err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic v, input logic sof, input logic [W-1:0] d);
    @(negedge clk);
    in_valid = v;
    in_sof   = sof;
    in_data  = d;
  endtask

  // Call right after driving the final slot beat.
  task automatic expect_frame(input logic [N*W-1:0] d);
    exp_t e;
    fc_model   = fc_model + 8'd1;
    last_frame = d;
    e.cyc  = cyc + 1;
    e.data = d;
    e.fc   = fc_model;
    exp_q.push_back(e);
  endtask

  task automatic expect_err();
    err_q.push_back(cyc + 1);
  endtask

  task automatic frame4(input logic [W-1:0] a, b, c, d);
    drive(1'b1, 1'b1, a);
    drive(1'b1, 1'b0, b);
    drive(1'b1, 1'b0, c);
    drive(1'b1, 1'b0, d);
    expect_frame({d, c, b, a});
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && err) chk("valid_err_overlap", 64'd1, 64'd0);
      if (out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_out_valid", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("frame_cycle", 64'(cyc), 64'(e.cyc));
          chk("ch_data", 64'(ch_data), 64'(e.data));
          chk("frame_cnt", 64'(frame_cnt), 64'(e.fc));
        end
      end
      if (err) begin
        if (err_q.size() == 0) chk("unexpected_err", 64'd1, 64'd0);
        else begin
          int ec;
          ec = err_q.pop_front();
          chk("err_cycle", 64'(cyc), 64'(ec));
        end
      end
      if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
        chk("missing_out_valid", 64'(cyc), 64'(exp_q[0].cyc));
        void'(exp_q.pop_front());
      end
      if (err_q.size() != 0 && cyc > err_q[0]) begin
        chk("missing_err", 64'(cyc), 64'(err_q[0]));
        void'(err_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected done before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ch_data", 64'(ch_data), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    rst_n = 1'b1;

    // Basic frame
    frame4(8'h11, 8'h22, 8'h33, 8'h44);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);

    // Non-SOF beats in HUNT are dropped
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h66);
    frame4(8'hA1, 8'hA2, 8'hA3, 8'hA4);
    drive(1'b0, 1'b0, 8'h00);

    // Short frame: second SOF aborts the partial
    drive(1'b1, 1'b1, 8'h01);
    drive(1'b1, 1'b0, 8'h02);
    drive(1'b1, 1'b1, 8'h10);
    expect_err();
    drive(1'b1, 1'b0, 8'h20);
    drive(1'b1, 1'b0, 8'h30);
    drive(1'b1, 1'b0, 8'h40);
    expect_frame(32'h40302010);
    drive(1'b0, 1'b0, 8'h00);

    // Timeout after 15 idle cycles
    drive(1'b1, 1'b1, 8'h01);
    for (int i = 1; i <= TIMEOUT; i++) begin
      drive(1'b0, 1'b0, 8'h00);
      if (i == TIMEOUT) expect_err();
    end
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    chk("timeout_ch_hold", 64'(ch_data), 64'(last_frame));
    // Back in HUNT: these non-SOF beats must not complete a frame
    drive(1'b1, 1'b0, 8'h99);
    drive(1'b1, 1'b0, 8'h98);
    drive(1'b1, 1'b0, 8'h97);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);

    // Beat on idle cycle 15 wins over the timeout
    drive(1'b1, 1'b1, 8'h05);
    for (int i = 1; i < TIMEOUT; i++) drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h06);
    drive(1'b1, 1'b0, 8'h07);
    drive(1'b1, 1'b0, 8'h08);
    expect_frame(32'h08070605);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);

    // Reset, then 256 back-to-back frames wrap frame_cnt to 0
    @(negedge clk);
    rst_n = 1'b0;
    fc_model = 8'd0;
    @(negedge clk);
    chk("rst2_ch_data", 64'(ch_data), 64'd0);
    rst_n = 1'b1;
    for (int f = 0; f < 256; f++) begin
      logic [7:0] b;
      b = 8'(f * 4);
      frame4(b, b + 8'd1, b + 8'd2, b + 8'd3);
    end
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    chk("wrap_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("wrap_ch_data", 64'(ch_data), 64'hFFFEFDFC);

    // Asynchronous reset during slot 2
    drive(1'b1, 1'b1, 8'hC1);
    drive(1'b1, 1'b0, 8'hC2);
    drive(1'b1, 1'b0, 8'hC3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ch_data", 64'(ch_data), 64'd0);
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_frame_cnt", 64'(frame_cnt), 64'd0);
    fc_model = 8'd0;
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    frame4(8'hD1, 8'hD2, 8'hD3, 8'hD4);
    drive(1'b0, 1'b0, 8'h00);
    repeat (4) @(negedge clk);
    chk("post_rst_frame_cnt", 64'(frame_cnt), 64'd1);

    chk("pending_frames", 64'(exp_q.size()), 64'd0);
    chk("pending_errs", 64'(err_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tdm_frame_demux.md
Name: tdm_frame_demux

Overview:
- Receive end of the team's MUX2-based time-division link.
- Takes a serial stream of W-bit slots, one slot per valid beat, with a start-of-frame marker on slot 0.
- Reassembles N slots into a frame and presents them as parallel registered channel outputs.
- Sits between the link sampler and the per-channel consumer logic; pulses once per good frame and flags framing errors.

Parameters:
- W, 8, slot/channel data width in bits (1..32).
- N, 4, slots per frame (2..16).
- TIMEOUT, 15, maximum consecutive idle cycles allowed inside a frame before abort (1..255).

Ports:
- clk  input  1  sole clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  W  slot data, sampled when in_valid=1.
- in_valid  input  1  slot beat qualifier.
- in_sof  input  1  start of frame; meaningful only with in_valid=1.
- ch_data  output  N*W  last good frame; slot k occupies bits [k*W +: W].
- out_valid  output  1  one-cycle pulse: ch_data updated this cycle.
- err  output  1  one-cycle pulse: frame aborted.
- frame_cnt  output  8  count of good frames, wraps 255 -> 0.

Behaviour:
- Reset (asynchronous assert, synchronous release): state=HUNT, slot counter=0, idle counter=0, shadow registers=0, ch_data=0, out_valid=0, err=0, frame_cnt=0.
- States: HUNT and COLLECT.
- Block always accepts beats; there is no backpressure.
- HUNT:
  - Beats with in_valid=1, in_sof=0 are discarded silently (no err).
  - Beat with in_valid=1, in_sof=1: store in_data as slot 0, slot counter=1, idle counter=0, go to COLLECT.
- COLLECT, beat with in_valid=1, in_sof=0:
  - Store in_data as slot[counter]; counter+1; idle counter=0.
  - If this is slot N-1: on the same edge copy all N slots (including this beat) into ch_data, assert out_valid for the next cycle only, increment frame_cnt, go to HUNT.
  - Latency: ch_data and out_valid are visible in the cycle after the final slot beat is sampled.
- COLLECT, beat with in_valid=1, in_sof=1 (short frame):
  - err pulses one cycle; partial frame discarded; ch_data unchanged.
  - This beat becomes slot 0 (counter=1), state stays COLLECT.
- COLLECT, in_valid=0:
  - Idle counter increments.
  - When it reaches TIMEOUT: err pulses one cycle, go to HUNT, ch_data unchanged.
  - A valid beat on the cycle the timeout is reached is processed normally and the timeout does not fire; the beat wins.
- Outputs:
  - out_valid and err are never asserted in the same cycle.
  - ch_data holds its value between good frames.
- Back-to-back frames: an SOF beat on the cycle immediately after a completing beat starts a new frame with no gap; sustained throughput is one frame per N cycles.
- Reset mid-frame: all state is cleared immediately and asynchronously; the partial frame is lost; ch_data=0.
- Wrap-around: frame_cnt wraps 255 -> 0 with no flag.

Test Plan:
- W=8, N=4: after reset, beats SOF+0x11, 0x22, 0x33, 0x44 on consecutive cycles -> next cycle ch_data=0x44332211, out_valid=1 for exactly one cycle, frame_cnt=1, err=0.
- Beats 0x55, 0x66 without SOF while in HUNT, then a good frame 0xA1..0xA4 -> only the good frame is captured (ch_data=0xA4A3A2A1); no err.
- SOF+0x01, 0x02, then SOF+0x10, 0x20, 0x30, 0x40 -> err pulses once, on the cycle after the second SOF; then ch_data=0x40302010, out_valid=1, frame_cnt increments by 1.
- TIMEOUT=15: SOF+0x01, then in_valid=0 for 15 cycles -> err pulses one cycle, ch_data keeps its previous value, FSM is in HUNT. Repeat with a valid beat on idle cycle 15 -> no err.
- 256 back-to-back good frames with in_valid held at 1 -> 256 out_valid pulses exactly N cycles apart; frame_cnt returns to 0.
- Assert rst_n low during slot 2 of a frame -> outputs clear within the same cycle without waiting for a clock edge; after release, a fresh good frame captures correctly with frame_cnt=1.
